uart_tx_fifo_drain: RTL

- Downstream consumer of the byte FIFO.
- Pops one word at a time using the FIFO's first-word-fall-through read data, and serialises it LSB-first as an 8N1 UART frame on `tx`.
- Contains its own 16x-oversampling baud tick generator.
- Never issues a read while the FIFO reports empty, so the FIFO's no-read-when-empty precondition holds by construction.

---
 rtl/uart_tx_fifo_drain_if.sv | 21 ++
 rtl/uart_tx_fifo_drain.sv | 131 +++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo_drain_if.sv
// FIFO read port seen by the UART drain: first-word-fall-through head word plus pop strobe.
// The master is the side that issues reads; the slave is the FIFO itself.
interface uart_tx_fifo_drain_if #(
    parameter int DBIT = 8
);
    logic            fifo_empty;
    logic [DBIT-1:0] fifo_data;
    logic            fifo_rd;

    modport master (
        input  fifo_empty,
        input  fifo_data,
        output fifo_rd
    );

    modport slave (
        output fifo_empty,
        output fifo_data,
        input  fifo_rd
    );
endinterface

// File: rtl/uart_tx_fifo_drain.sv
// Pops bytes from a FWFT FIFO and sends each LSB-first as an 8N1 UART frame on a registered tx line.
// Pops combinationally in the IDLE cycle; never pops while empty or in reset; frame unaffected by later FIFO activity.
module uart_tx_fifo_drain #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 163,
    parameter int DVSR_W  = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    uart_tx_fifo_drain_if.master  fifo,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [4:0]        S_LAST  = 5'd15;
    localparam logic [4:0]        SB_LAST = 5'(SB_TICK - 1);
    localparam logic [NW-1:0]     N_LAST  = NW'(DBIT - 1);
    localparam logic [DVSR_W-1:0] B_LAST  = DVSR_W'(DVSR - 1);

    logic [DVSR_W-1:0] baud_q, baud_d;
    logic [1:0]        state_q, state_d;
    logic [4:0]        s_cnt_q, s_cnt_d;
    logic [NW-1:0]     n_cnt_q, n_cnt_d;
    logic [DBIT-1:0]   sh_q, sh_d;
    logic              tx_q, tx_d;
    logic              s_tick;
    logic              rd;
    logic              done;

    // Free-running oversampling tick; deliberately not re-phased at frame start.
    assign s_tick = (baud_q == B_LAST);
    assign baud_d = s_tick ? '0 : baud_q + 1'b1;

    always_comb begin
        state_d = state_q;
        s_cnt_d = s_cnt_q;
        n_cnt_d = n_cnt_q;
        sh_d    = sh_q;
        rd      = 1'b0;
        done    = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo.fifo_empty && !reset) begin
                    rd      = 1'b1;
                    sh_d    = fifo.fifo_data;
                    s_cnt_d = '0;
                    state_d = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        n_cnt_d = '0;
                        state_d = DATA;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_cnt_q == S_LAST) begin
                        s_cnt_d = '0;
                        sh_d    = sh_q >> 1;
                        if (n_cnt_q == N_LAST) begin
                            state_d = STOP;
                        end else begin
                            n_cnt_d = n_cnt_q + 1'b1;
                        end
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            STOP: begin
                if (s_tick) begin
                    if (s_cnt_q == SB_LAST) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        s_cnt_d = s_cnt_q + 5'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // tx follows the next state so the line changes on the same edge as the FSM.
    always_comb begin
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = sh_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            baud_q  <= '0;
            state_q <= IDLE;
            s_cnt_q <= '0;
            n_cnt_q <= '0;
            sh_q    <= '0;
            tx_q    <= 1'b1;
        end else begin
            baud_q  <= baud_d;
            state_q <= state_d;
            s_cnt_q <= s_cnt_d;
            n_cnt_q <= n_cnt_d;
            sh_q    <= sh_d;
            tx_q    <= tx_d;
        end
    end

    assign fifo.fifo_rd = rd;
    assign tx           = tx_q;
    assign busy         = (state_q != IDLE);
    assign tx_done      = done;

endmodule
